// File: rtl/timer_capture_collector.sv
// rtl/timer_capture_collector.sv - capture-event collector: edge detect, round-robin arbiter, FWFT event FIFO
// Each record carries the channel id and the latched counter value; a repeat capture before the grant overwrites the value and flags overrun.
module timer_capture_collector #(
    parameter int TIMER_BITWIDTH = 32,
    parameter int NB_CAPTURES    = 10,
    parameter int FIFO_DEPTH     = 8,
    localparam int ID_W          = $clog2(NB_CAPTURES),
    localparam int LVL_W         = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                                  clk_in,
    input  logic                                  rst_in,
    input  logic                                  clear_in,
    input  logic [NB_CAPTURES-1:0]                captured_in,
    input  logic [NB_CAPTURES*TIMER_BITWIDTH-1:0] capture_value_in,
    output logic                                  evt_valid_out,
    input  logic                                  evt_ready_in,
    output logic [ID_W-1:0]                       evt_id_out,
    output logic [TIMER_BITWIDTH-1:0]             evt_time_out,
    output logic [LVL_W-1:0]                      fifo_level_out,
    output logic [NB_CAPTURES-1:0]                overrun_out
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [LVL_W-1:0] DEPTH_L = LVL_W'(FIFO_DEPTH);

    logic [NB_CAPTURES-1:0]    captured_d;
    logic [NB_CAPTURES-1:0]    pending;
    logic [NB_CAPTURES-1:0]    overrun;
    logic [TIMER_BITWIDTH-1:0] value [NB_CAPTURES];
    logic [ID_W-1:0]           ptr;

    logic [ID_W-1:0]           mem_id   [FIFO_DEPTH];
    logic [TIMER_BITWIDTH-1:0] mem_time [FIFO_DEPTH];
    logic [AW-1:0]             wr_ptr;
    logic [AW-1:0]             rd_ptr;
    logic [LVL_W-1:0]          level;

    logic [NB_CAPTURES-1:0]    event_v;
    logic [NB_CAPTURES-1:0]    rot;
    logic [NB_CAPTURES-1:0]    granted;
    logic                      grant_valid;
    logic [ID_W-1:0]           grant_id;
    logic [ID_W-1:0]           next_ptr;
    logic                      pop;
    logic                      push;
    logic                      can_accept;
    int                        sum;

    assign event_v = captured_in & ~captured_d;

    // Rotate pending so that bit 0 is the channel at ptr; first set bit wins.
    assign rot = NB_CAPTURES'({pending, pending} >> ptr);

    always_comb begin
        grant_valid = 1'b0;
        grant_id    = '0;
        sum         = 0;
        for (int k = 0; k < NB_CAPTURES; k++) begin
            if (!grant_valid && rot[k]) begin
                grant_valid = 1'b1;
                sum         = int'(ptr) + k;
                if (sum >= NB_CAPTURES)
                    sum = sum - NB_CAPTURES;
                grant_id    = ID_W'(sum);
            end
        end
    end

    assign next_ptr      = (grant_id == ID_W'(NB_CAPTURES - 1)) ? '0 : grant_id + ID_W'(1);
    assign evt_valid_out = (level != '0);
    assign pop           = evt_valid_out && evt_ready_in;
    assign can_accept    = (level < DEPTH_L) || pop;
    assign push          = grant_valid && can_accept;
    assign granted       = push ? (NB_CAPTURES'(1) << grant_id) : '0;

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            captured_d <= '0;
            pending    <= '0;
            overrun    <= '0;
            ptr        <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            level      <= '0;
            for (int i = 0; i < NB_CAPTURES; i++)
                value[i] <= '0;
        end else if (clear_in) begin
            // Loading captured_d hides flags that are already high.
            captured_d <= captured_in;
            pending    <= '0;
            overrun    <= '0;
            ptr        <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            level      <= '0;
        end else begin
            captured_d <= captured_in;
            pending    <= (pending & ~granted) | event_v;
            overrun    <= overrun | (event_v & pending & ~granted);
            for (int i = 0; i < NB_CAPTURES; i++) begin
                if (event_v[i])
                    value[i] <= capture_value_in[i*TIMER_BITWIDTH +: TIMER_BITWIDTH];
            end
            if (push) begin
                ptr    <= next_ptr;
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop)
                rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   level <= level + LVL_W'(1);
                2'b01:   level <= level - LVL_W'(1);
                default: level <= level;
            endcase
        end
    end

    // The pushed value is the registered one, so a same-cycle new capture stays pending.
    always_ff @(posedge clk_in) begin
        if (push && !clear_in) begin
            mem_id[wr_ptr]   <= grant_id;
            mem_time[wr_ptr] <= value[grant_id];
        end
    end

    assign evt_id_out     = evt_valid_out ? mem_id[rd_ptr] : '0;
    assign evt_time_out   = evt_valid_out ? mem_time[rd_ptr] : '0;
    assign fifo_level_out = level;
    assign overrun_out    = overrun;

endmodule

// File: tb/tb_timer_capture_collector.sv
// tb/tb_timer_capture_collector.sv - bench for timer_capture_collector with a queue-based reference model
module tb_timer_capture_collector;

    localparam int W    = 32;
    localparam int NB   = 10;
    localparam int D    = 8;
    localparam int ID_W = 4;
    localparam int LW   = 4;

    logic               clk = 1'b0;
    logic               rst;
    logic               clear;
    logic [NB-1:0]      cap;
    logic [NB*W-1:0]    cv;
    logic               ready;
    logic               valid;
    logic [ID_W-1:0]    id;
    logic [W-1:0]       tm;
    logic [LW-1:0]      level;
    logic [NB-1:0]      ovr;

    int total = 0;
    int bad   = 0;

    // Reference model: pending set, latched values, sticky overrun, and the FIFO as a queue.
    logic [NB-1:0] m_pend;
    logic [NB-1:0] m_capd;
    logic [NB-1:0] m_ovr;
    logic [W-1:0]  m_val [NB];
    int            m_ptr;
    int            q_id [$];
    logic [W-1:0]  q_t [$];

    timer_capture_collector #(
        .TIMER_BITWIDTH(W), .NB_CAPTURES(NB), .FIFO_DEPTH(D)
    ) dut (
        .clk_in(clk), .rst_in(rst), .clear_in(clear),
        .captured_in(cap), .capture_value_in(cv),
        .evt_valid_out(valid), .evt_ready_in(ready),
        .evt_id_out(id), .evt_time_out(tm),
        .fifo_level_out(level), .overrun_out(ovr)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic model_reset();
        m_pend = '0; m_capd = '0; m_ovr = '0; m_ptr = 0;
        for (int i = 0; i < NB; i++) m_val[i] = '0;
        q_id.delete(); q_t.delete();
    endtask

    task automatic model_step();
        bit pop_now;
        int g;
        if (rst) begin
            model_reset();
        end else if (clear) begin
            m_pend = '0; m_ovr = '0; m_ptr = 0;
            q_id.delete(); q_t.delete();
            m_capd = cap;
        end else begin
            pop_now = (q_id.size() > 0) && ready;
            g = -1;
            for (int k = 0; k < NB; k++)
                if (g < 0 && m_pend[(m_ptr + k) % NB]) g = (m_ptr + k) % NB;
            if (pop_now) begin
                void'(q_id.pop_front());
                void'(q_t.pop_front());
            end
            if (g >= 0 && (q_id.size() < D)) begin
                q_id.push_back(g);
                q_t.push_back(m_val[g]);
                m_pend[g] = 1'b0;
                m_ptr = (g + 1) % NB;
            end
            for (int i = 0; i < NB; i++) begin
                if (cap[i] && !m_capd[i]) begin
                    if (m_pend[i]) m_ovr[i] = 1'b1;
                    m_pend[i] = 1'b1;
                    m_val[i]  = cv[i*W +: W];
                end
            end
            m_capd = cap;
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_cv(input int ch, input logic [W-1:0] v);
        cv[ch*W +: W] = v;
    endtask

    task automatic do_clear();
        cap = '0;
        tick();
        clear = 1'b1;
        tick();
        clear = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; clear = 1'b0; cap = '0; cv = '0; ready = 1'b0;
        model_reset();
        repeat (2) tick();
        total++; if (valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%0d exp=0", valid); end
        total++; if (id !== '0) begin bad++; $display("FAIL reset_id got=%0d exp=0", id); end
        total++; if (tm !== '0) begin bad++; $display("FAIL reset_time got=%0h exp=0", tm); end
        total++; if (level !== '0) begin bad++; $display("FAIL reset_level got=%0d exp=0", level); end
        total++; if (ovr !== '0) begin bad++; $display("FAIL reset_overrun got=%0h exp=0", ovr); end
        cap[7] = 1'b1; set_cv(7, 32'd77);
        tick();
        rst = 1'b0;
        tick();
        tick();
        total++; if (valid !== 1'b1 || id !== 4'd7 || tm !== 32'd77) begin
            bad++; $display("FAIL reset_release_event got v=%0d id=%0d t=%0d exp v=1 id=7 t=77", valid, id, tm);
        end
        ready = 1'b1;
        tick();
        cap = '0;
        tick();
    endtask

    task automatic test_single();
        do_clear();
        ready = 1'b1;
        cap[3] = 1'b1; set_cv(3, 32'h0000_1234);
        tick();
        total++; if (valid !== 1'b0) begin bad++; $display("FAIL single_early got=%0d exp=0", valid); end
        tick();
        total++; if (valid !== 1'b1 || id !== 4'd3 || tm !== 32'h1234) begin
            bad++; $display("FAIL single_record got v=%0d id=%0d t=%0h exp v=1 id=3 t=1234", valid, id, tm);
        end
        total++; if (level !== 4'd1) begin bad++; $display("FAIL single_level1 got=%0d exp=1", level); end
        tick();
        total++; if (level !== 4'd0 || valid !== 1'b0) begin
            bad++; $display("FAIL single_drained got lvl=%0d v=%0d exp lvl=0 v=0", level, valid);
        end
        cap = '0;
        tick();
    endtask

    task automatic test_round_robin();
        int exp_id [3];
        int exp_t  [3];
        exp_id = '{0, 5, 9};
        exp_t  = '{10, 50, 90};
        do_clear();
        ready = 1'b1;
        cap[0] = 1'b1; cap[5] = 1'b1; cap[9] = 1'b1;
        set_cv(0, 32'd10); set_cv(5, 32'd50); set_cv(9, 32'd90);
        tick();
        for (int i = 0; i < 3; i++) begin
            tick();
            total++; if (valid !== 1'b1 || int'(id) != exp_id[i] || tm !== W'(exp_t[i])) begin
                bad++; $display("FAIL rr_order%0d got v=%0d id=%0d t=%0d exp id=%0d t=%0d", i, valid, id, tm, exp_id[i], exp_t[i]);
            end
        end
        cap = '0;
        tick();
        cap[5] = 1'b1; set_cv(5, 32'd55);
        repeat (3) tick();
        cap = '0;
        tick();
        cap[0] = 1'b1; cap[9] = 1'b1; set_cv(0, 32'd1); set_cv(9, 32'd99);
        tick();
        tick();
        total++; if (valid !== 1'b1 || id !== 4'd9 || tm !== 32'd99) begin
            bad++; $display("FAIL rr_wrap_first got v=%0d id=%0d t=%0d exp id=9 t=99", valid, id, tm);
        end
        tick();
        total++; if (valid !== 1'b1 || id !== 4'd0 || tm !== 32'd1) begin
            bad++; $display("FAIL rr_wrap_second got v=%0d id=%0d t=%0d exp id=0 t=1", valid, id, tm);
        end
        cap = '0;
        tick();
    endtask

    task automatic test_backpressure();
        do_clear();
        ready = 1'b0;
        for (int i = 0; i < NB; i++) begin
            cap[i] = 1'b1; set_cv(i, W'(1000 + i));
        end
        tick();
        repeat (10) tick();
        total++; if (level !== 4'd8) begin bad++; $display("FAIL bp_saturate got=%0d exp=8", level); end
        total++; if (ovr !== '0) begin bad++; $display("FAIL bp_no_overrun got=%0h exp=0", ovr); end
        ready = 1'b1;
        for (int i = 0; i < NB; i++) begin
            total++; if (valid !== 1'b1 || int'(id) != i || tm !== W'(1000 + i)) begin
                bad++; $display("FAIL bp_drain%0d got v=%0d id=%0d t=%0d exp id=%0d t=%0d", i, valid, id, tm, i, 1000 + i);
            end
            tick();
        end
        total++; if (valid !== 1'b0 || level !== 4'd0 || ovr !== '0) begin
            bad++; $display("FAIL bp_end got v=%0d lvl=%0d ovr=%0h exp 0 0 0", valid, level, ovr);
        end
        cap = '0;
        tick();
    endtask

    task automatic test_overrun();
        int n2;
        logic [W-1:0] t2;
        n2 = 0; t2 = '0;
        do_clear();
        ready = 1'b0;
        for (int i = 0; i < 9; i++) begin
            if (i != 2) begin cap[i] = 1'b1; set_cv(i, W'(i)); end
        end
        tick();
        repeat (8) tick();
        total++; if (level !== 4'd8) begin bad++; $display("FAIL ovr_full got=%0d exp=8", level); end
        cap[2] = 1'b1; set_cv(2, 32'd100);
        tick();
        cap[2] = 1'b0;
        tick();
        cap[2] = 1'b1; set_cv(2, 32'd200);
        tick();
        total++; if (ovr !== 10'b00_0000_0100) begin bad++; $display("FAIL ovr_flag got=%0h exp=004", ovr); end
        ready = 1'b1;
        for (int c = 0; c < 12; c++) begin
            if (valid === 1'b1 && id === 4'd2) begin n2++; t2 = tm; end
            tick();
        end
        total++; if (n2 != 1 || t2 !== 32'd200) begin
            bad++; $display("FAIL ovr_single_record got n=%0d t=%0d exp n=1 t=200", n2, t2);
        end
        total++; if (ovr !== 10'b00_0000_0100 || level !== 4'd0) begin
            bad++; $display("FAIL ovr_sticky got ovr=%0h lvl=%0d exp ovr=004 lvl=0", ovr, level);
        end
        cap = '0;
        tick();
    endtask

    task automatic test_same_cycle();
        do_clear();
        ready = 1'b1;
        cap[0] = 1'b1; cap[1] = 1'b1; set_cv(0, 32'd5); set_cv(1, 32'd11);
        tick();
        cap = '0;
        tick();
        total++; if (valid !== 1'b1 || id !== 4'd0 || tm !== 32'd5) begin
            bad++; $display("FAIL same_first got v=%0d id=%0d t=%0d exp id=0 t=5", valid, id, tm);
        end
        cap[1] = 1'b1; set_cv(1, 32'd22);
        tick();
        total++; if (valid !== 1'b1 || id !== 4'd1 || tm !== 32'd11) begin
            bad++; $display("FAIL same_old got v=%0d id=%0d t=%0d exp id=1 t=11", valid, id, tm);
        end
        tick();
        total++; if (valid !== 1'b1 || id !== 4'd1 || tm !== 32'd22) begin
            bad++; $display("FAIL same_new got v=%0d id=%0d t=%0d exp id=1 t=22", valid, id, tm);
        end
        total++; if (ovr !== '0) begin bad++; $display("FAIL same_no_overrun got=%0h exp=0", ovr); end
        tick();
        total++; if (valid !== 1'b0) begin bad++; $display("FAIL same_empty got=%0d exp=0", valid); end
        cap = '0;
        tick();
    endtask

    task automatic test_clear();
        do_clear();
        ready = 1'b0;
        cap[4] = 1'b1; cap[6] = 1'b1; cap[7] = 1'b1;
        set_cv(4, 32'd44); set_cv(6, 32'd66); set_cv(7, 32'd77);
        tick();
        repeat (3) tick();
        total++; if (level !== 4'd3) begin bad++; $display("FAIL clr_queued got=%0d exp=3", level); end
        clear = 1'b1;
        tick();
        clear = 1'b0;
        total++; if (level !== 4'd0 || valid !== 1'b0 || ovr !== '0) begin
            bad++; $display("FAIL clr_state got lvl=%0d v=%0d ovr=%0h exp 0 0 0", level, valid, ovr);
        end
        repeat (3) tick();
        total++; if (level !== 4'd0) begin bad++; $display("FAIL clr_held_high got=%0d exp=0", level); end
        cap[4] = 1'b0;
        tick();
        cap[4] = 1'b1; set_cv(4, 32'd144);
        tick();
        tick();
        total++; if (level !== 4'd1 || id !== 4'd4 || tm !== 32'd144) begin
            bad++; $display("FAIL clr_reedge got lvl=%0d id=%0d t=%0d exp lvl=1 id=4 t=144", level, id, tm);
        end
        cap = '0;
        ready = 1'b1;
        tick();
    endtask

    task automatic test_async_reset();
        do_clear();
        ready = 1'b0;
        cap[1] = 1'b1; cap[2] = 1'b1; cap[3] = 1'b1;
        set_cv(1, 32'hA1); set_cv(2, 32'hA2); set_cv(3, 32'hA3);
        tick();
        repeat (3) tick();
        ready = 1'b1;
        tick();
        #3;
        rst = 1'b1;
        #1;
        total++; if (valid !== 1'b0 || id !== '0 || tm !== '0 || level !== '0 || ovr !== '0) begin
            bad++; $display("FAIL async_reset got v=%0d id=%0d t=%0h lvl=%0d ovr=%0h exp all 0", valid, id, tm, level, ovr);
        end
        cap = '0;
        model_reset();
        tick();
        rst = 1'b0;
        tick();
        total++; if (valid !== 1'b0) begin bad++; $display("FAIL async_after got=%0d exp=0", valid); end
    endtask

    task automatic test_random();
        int rp;
        int errs;
        errs = 0;
        do_clear();
        for (int c = 0; c < 600; c++) begin
            rp = (c / 100) % 2 == 0 ? 25 : 85;
            for (int i = 0; i < NB; i++) begin
                if ($urandom_range(0, 7) == 0) cap[i] = ~cap[i];
                cv[i*W +: W] = $urandom;
            end
            ready = ($urandom_range(0, 99) < rp);
            clear = ($urandom_range(0, 199) == 0);
            tick();
            total++; if (valid !== (q_id.size() > 0)) begin
                bad++; errs++; if (errs < 20) $display("FAIL rnd_valid c=%0d got=%0d exp=%0d", c, valid, q_id.size() > 0);
            end
            total++; if (level !== LW'(q_id.size())) begin
                bad++; errs++; if (errs < 20) $display("FAIL rnd_level c=%0d got=%0d exp=%0d", c, level, q_id.size());
            end
            total++; if (ovr !== m_ovr) begin
                bad++; errs++; if (errs < 20) $display("FAIL rnd_overrun c=%0d got=%0h exp=%0h", c, ovr, m_ovr);
            end
            if (q_id.size() > 0) begin
                total++; if (int'(id) != q_id[0] || tm !== q_t[0]) begin
                    bad++; errs++; if (errs < 20) $display("FAIL rnd_head c=%0d got id=%0d t=%0h exp id=%0d t=%0h", c, id, tm, q_id[0], q_t[0]);
                end
            end
        end
        clear = 1'b0;
        cap = '0;
        tick();
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_backpressure();
        test_overrun();
        test_same_cycle();
        test_clear();
        test_async_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
